watchdog_supervisor_ctrl: RTL
=============================

// Module: watchdog_supervisor_ctrl
// PURPOSE
//  Sequencer that drives a watchdog counter (enable/restart/remove_flag) from N heartbeat sources.
//  Issues a restart only after every masked source has shown a heartbeat since the last restart.
//  On a watchdog trip it runs a recovery sequence: timed reset pulse, flag clear, re-arm.
//  Sits between the watchdog counter and the blocks it supervises; counts trips.
// PARAMETERS
//  N_SRC        4   number of heartbeat sources
//  ARM_DELAY    4   cycles spent in ARM before supervision starts (>=1)
//  HOLD_CYCLES  16  cycles sys_rst is held high after a trip (>=1)
//  HOLD_W       5   width of arm/hold down-counter; must hold max(ARM_DELAY,HOLD_CYCLES)
//  CNT_W        4   width of saturating trip counter
// PORTS
//  clk            in   1       single clock, all logic rising-edge
//  rst            in   1       asynchronous, active-high reset
//  ctrl_en        in   1       supervision enable (level)
//  src_mask       in   N_SRC   1 = source required for restart
//  heartbeat      in   N_SRC   per-source activity pulse, sampled every cycle
//  trip_clr       in   1       synchronous clear of trip_count
//  wd_rst_b       in   1       watchdog trip output, active-low
//  wd_flag        in   1       watchdog sticky flag
//  wd_enable      out  1       to watchdog enable
//  wd_rstrt       out  1       to watchdog restart, one-cycle pulse
//  wd_remove_flag out  1       to watchdog remove_flag
//  sys_rst        out  1       recovery reset to supervised logic, active-high
//  trip_count     out  CNT_W   number of trips, saturating
//  state          out  3       FSM state code
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, trip_count=0, seen=0, counter=0. Asserting rst at any time,
//   including mid-HOLD, forces this state immediately (sys_rst falls asynchronously).
//  Outputs are decodes of registered state; a condition seen in cycle t takes effect in t+1.
//  States/codes: IDLE=0 ARM=1 RUN=2 KICK=3 TRIP=4 HOLD=5 CLEAR=6; code 7 unused -> IDLE.
//  IDLE: all outputs 0. ctrl_en=1 -> ARM, counter=ARM_DELAY-1.
//  ARM: wd_enable=1; wd_rstrt=1 in first ARM cycle only; counter decrements; seen cleared;
//   at counter==0 -> RUN.
//  RUN: wd_enable=1; seen |= heartbeat & src_mask each cycle.
//   If (seen_next | ~src_mask) all ones and src_mask!=0 -> KICK. src_mask==0: no kicks ever.
//  KICK: wd_enable=1, wd_rstrt=1 for exactly this cycle; seen <= heartbeat & src_mask
//   (heartbeats in the KICK cycle count toward the next window); -> RUN.
//  Trip: wd_rst_b==0 sampled in ARM/RUN/KICK -> TRIP; takes priority over KICK and ctrl_en drop.
//  TRIP (1 cycle): wd_enable=1; trip_count+1 saturating at 2^CNT_W-1; -> HOLD,
//   counter=HOLD_CYCLES-1.
//  HOLD: sys_rst=1, wd_enable=0; exactly HOLD_CYCLES cycles; ctrl_en ignored; -> CLEAR.
//  CLEAR: wd_remove_flag=1, wd_enable=0; held until wd_flag==0 sampled,
//   then -> ARM if ctrl_en=1 else IDLE.
//  ctrl_en=0 in ARM/RUN/KICK (no trip same cycle) -> IDLE next cycle; seen cleared.
//  trip_clr: trip_count<=0; with a simultaneous TRIP increment, result is 1.
//  wd_rst_b/wd_flag ignored in IDLE; no trip counted there.
// TESTING
//  T1 reset: assert rst mid-run -> state=0, all outputs 0, trip_count=0 in same cycle.
//  T2 kick: ctrl_en=1, mask=4'b0011; hb[0] at c10, hb[2] c11, hb[1] c14 -> single wd_rstrt at
//   c15; no pulse before; hb[2]/hb[3] alone never kick.
//  T3 trip: in RUN drive wd_rst_b=0 one cycle, wd_flag=1 -> TRIP, trip_count 0->1,
//   sys_rst high exactly 16 cycles, wd_remove_flag high until wd_flag=0, then ARM with
//   one wd_rstrt pulse, RUN after 4 ARM cycles.
//  T4 priority: all sources heartbeat in the same cycle that wd_rst_b=0 -> TRIP, no wd_rstrt.
//  T5 saturation/clear: 17 trips -> trip_count=15; trip_clr with 18th trip -> 1.
//  T6 enable: ctrl_en=0 in RUN -> IDLE next cycle; ctrl_en=0 during HOLD -> full 16-cycle hold,
//   CLEAR, then IDLE.

Source files
------------

// File: rtl/watchdog_supervisor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_supervisor_ctrl_if
// Brief    : Signal bundle between the watchdog supervisor, its heartbeat
//            sources, the watchdog counter and the supervised logic.
//            master = supervisor side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface watchdog_supervisor_ctrl_if #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 4
);
    logic             ctrl_en;
    logic [N_SRC-1:0] src_mask;
    logic [N_SRC-1:0] heartbeat;
    logic             trip_clr;
    logic             wd_rst_b;
    logic             wd_flag;
    logic             wd_enable;
    logic             wd_rstrt;
    logic             wd_remove_flag;
    logic             sys_rst;
    logic [CNT_W-1:0] trip_count;
    logic [2:0]       state;

    modport master (
        input  ctrl_en, src_mask, heartbeat, trip_clr, wd_rst_b, wd_flag,
        output wd_enable, wd_rstrt, wd_remove_flag, sys_rst, trip_count, state
    );

    modport slave (
        output ctrl_en, src_mask, heartbeat, trip_clr, wd_rst_b, wd_flag,
        input  wd_enable, wd_rstrt, wd_remove_flag, sys_rst, trip_count, state
    );
endinterface
`default_nettype wire

// File: rtl/watchdog_supervisor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_supervisor_ctrl
// Brief    : Sequencer driving a watchdog counter from N heartbeat sources.
//            Restarts the watchdog once every required source has shown a
//            heartbeat since the previous restart; on a trip it holds the
//            supervised logic in reset, clears the watchdog flag and re-arms.
// Revision : 1.0 - initial release
// ============================================================================
module watchdog_supervisor_ctrl #(
    parameter int N_SRC       = 4,
    parameter int ARM_DELAY   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int HOLD_W      = 5,
    parameter int CNT_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    watchdog_supervisor_ctrl_if.master bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARM   = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_KICK  = 3'd3;
    localparam logic [2:0] c_ST_TRIP  = 3'd4;
    localparam logic [2:0] c_ST_HOLD  = 3'd5;
    localparam logic [2:0] c_ST_CLEAR = 3'd6;

    // Down-counter reload values; ARM/HOLD last exactly load+1 cycles.
    localparam logic [HOLD_W-1:0] c_ARM_LOAD  = HOLD_W'(ARM_DELAY - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_TRIP_MAX  = {CNT_W{1'b1}};

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic [N_SRC-1:0]  r_seen;
    logic [N_SRC-1:0]  w_seen_nxt;
    logic [CNT_W-1:0]  r_trip_count;

    logic [N_SRC-1:0]  w_hb_masked;
    logic [N_SRC-1:0]  w_seen_upd;
    logic              w_all_seen;
    logic              w_trip;
    logic              w_cnt_zero;
    logic [HOLD_W-1:0] w_cnt_dec;

    logic              w_wd_enable;
    logic              w_wd_rstrt;
    logic              w_wd_remove_flag;
    logic              w_sys_rst;

    // Unmasked sources are treated as permanently seen; an all-zero mask
    // would otherwise satisfy the reduction trivially, so it never kicks.
    assign w_hb_masked = bus.heartbeat & bus.src_mask;
    assign w_seen_upd  = r_seen | w_hb_masked;
    assign w_all_seen  = (&(w_seen_upd | ~bus.src_mask)) && (|bus.src_mask);
    assign w_trip      = ~bus.wd_rst_b;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_cnt_dec   = r_cnt - HOLD_W'(1);

    // State register together with the window and delay bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_seen  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seen  <= w_seen_nxt;
        end
    end

    // Next-state decode; a trip outranks both a pending kick and an enable drop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seen_nxt  = r_seen;
        case (r_state)
            c_ST_IDLE: begin
                w_seen_nxt = '0;
                if (bus.ctrl_en) begin
                    w_state_nxt = c_ST_ARM;
                    w_cnt_nxt   = c_ARM_LOAD;
                end
            end
            c_ST_ARM: begin
                w_seen_nxt = '0;
                if (w_trip) begin
                    w_state_nxt = c_ST_TRIP;
                end else if (!bus.ctrl_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_ST_RUN: begin
                if (w_trip) begin
                    w_state_nxt = c_ST_TRIP;
                    w_seen_nxt  = '0;
                end else if (!bus.ctrl_en) begin
                    w_state_nxt = c_ST_IDLE;
                    w_seen_nxt  = '0;
                end else begin
                    w_seen_nxt = w_seen_upd;
                    if (w_all_seen) begin
                        w_state_nxt = c_ST_KICK;
                    end
                end
            end
            c_ST_KICK: begin
                if (w_trip) begin
                    w_state_nxt = c_ST_TRIP;
                    w_seen_nxt  = '0;
                end else if (!bus.ctrl_en) begin
                    w_state_nxt = c_ST_IDLE;
                    w_seen_nxt  = '0;
                end else begin
                    // Heartbeats arriving alongside the restart open the next window.
                    w_seen_nxt  = w_hb_masked;
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_TRIP: begin
                w_state_nxt = c_ST_HOLD;
                w_cnt_nxt   = c_HOLD_LOAD;
                w_seen_nxt  = '0;
            end
            c_ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_CLEAR;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_ST_CLEAR: begin
                if (!bus.wd_flag) begin
                    if (bus.ctrl_en) begin
                        w_state_nxt = c_ST_ARM;
                        w_cnt_nxt   = c_ARM_LOAD;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
                w_seen_nxt  = '0;
            end
        endcase
    end

    // Saturating trip counter; a clear coinciding with a trip leaves one trip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trip_count <= '0;
        end else if (bus.trip_clr) begin
            r_trip_count <= (r_state == c_ST_TRIP) ? CNT_W'(1) : '0;
        end else if ((r_state == c_ST_TRIP) && (r_trip_count != c_TRIP_MAX)) begin
            r_trip_count <= r_trip_count + CNT_W'(1);
        end
    end

    // Output decode from registered state only; restart fires on the first
    // ARM cycle, recognised by the counter still holding its reload value.
    always_comb begin
        w_wd_enable      = 1'b0;
        w_wd_rstrt       = 1'b0;
        w_wd_remove_flag = 1'b0;
        w_sys_rst        = 1'b0;
        case (r_state)
            c_ST_ARM: begin
                w_wd_enable = 1'b1;
                w_wd_rstrt  = (r_cnt == c_ARM_LOAD);
            end
            c_ST_RUN: begin
                w_wd_enable = 1'b1;
            end
            c_ST_KICK: begin
                w_wd_enable = 1'b1;
                w_wd_rstrt  = 1'b1;
            end
            c_ST_TRIP: begin
                w_wd_enable = 1'b1;
            end
            c_ST_HOLD: begin
                w_sys_rst = 1'b1;
            end
            c_ST_CLEAR: begin
                w_wd_remove_flag = 1'b1;
            end
            default: begin
                w_wd_enable = 1'b0;
            end
        endcase
    end

    assign bus.wd_enable      = w_wd_enable;
    assign bus.wd_rstrt       = w_wd_rstrt;
    assign bus.wd_remove_flag = w_wd_remove_flag;
    assign bus.sys_rst        = w_sys_rst;
    assign bus.trip_count     = r_trip_count;
    assign bus.state          = r_state;

endmodule
`default_nettype wire
